// File: rtl/fw_pkg.sv
// Shared types and constants for the forwarding / hazard unit.
package fw_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREG   = 32;

  // Forwarding stage indices, youngest first.
  localparam int unsigned STG_EX  = 0;
  localparam int unsigned STG_MEM = 1;
  localparam int unsigned STG_WB  = 2;

  // Where a read port's data came from this cycle.
  typedef enum logic [1:0] {
    SRC_REG = 2'd0,
    SRC_STG = 2'd1,
    SRC_LW  = 2'd2
  } fwd_src_e;

endpackage

// File: rtl/fw_hazard_unit_if.sv
// ID-stage hazard bus: read ports, stage writebacks, issue info and resolved results.
interface fw_hazard_unit_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NRP      = 2,
  parameter int unsigned NSTG     = 3,
  parameter int unsigned MAX_LONG = 4
);
  import fw_pkg::*;

  localparam int unsigned CNT_W = $clog2(MAX_LONG + 1);

  logic [NRP-1:0]                rs_re_i;
  logic [NRP-1:0][REG_AW-1:0]    rs_addr_i;
  logic [NRP-1:0][XLEN-1:0]      rs_data_reg_i;
  logic [NSTG-1:0]               stg_we_i;
  logic [NSTG-1:0][REG_AW-1:0]   stg_addr_i;
  logic [NSTG-1:0]               stg_dv_i;
  logic [NSTG-1:0][XLEN-1:0]     stg_data_i;
  logic                          issue_i;
  logic                          issue_we_i;
  logic                          issue_long_i;
  logic [REG_AW-1:0]             issue_rd_i;
  logic                          flush_i;
  logic                          lw_done_i;
  logic [REG_AW-1:0]             lw_addr_i;
  logic [XLEN-1:0]               lw_data_i;
  logic [NRP-1:0][XLEN-1:0]      rs_data_o;
  logic                          stall_o;
  logic [CNT_W-1:0]              long_cnt_o;
  logic [31:0]                   perf_stall_o;
  logic [31:0]                   perf_fwd_o;

  modport slave (
    input  rs_re_i, rs_addr_i, rs_data_reg_i,
    input  stg_we_i, stg_addr_i, stg_dv_i, stg_data_i,
    input  issue_i, issue_we_i, issue_long_i, issue_rd_i, flush_i,
    input  lw_done_i, lw_addr_i, lw_data_i,
    output rs_data_o, stall_o, long_cnt_o, perf_stall_o, perf_fwd_o
  );

  modport master (
    output rs_re_i, rs_addr_i, rs_data_reg_i,
    output stg_we_i, stg_addr_i, stg_dv_i, stg_data_i,
    output issue_i, issue_we_i, issue_long_i, issue_rd_i, flush_i,
    output lw_done_i, lw_addr_i, lw_data_i,
    input  rs_data_o, stall_o, long_cnt_o, perf_stall_o, perf_fwd_o
  );

endinterface

// File: rtl/fw_scoreboard.sv
// Busy-register scoreboard and outstanding long-latency write counter.
module fw_scoreboard
  import fw_pkg::*;
#(
  parameter int unsigned MAX_LONG = 4,
  parameter int unsigned CNT_W    = $clog2(MAX_LONG + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_i,
  input  logic [REG_AW-1:0] set_rd_i,
  input  logic              inc_i,
  input  logic              clr_i,
  input  logic [REG_AW-1:0] clr_addr_i,
  output logic [NREG-1:0]   busy_o,
  output logic [CNT_W-1:0]  long_cnt_o
);

  logic [NREG-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clr_ok, inc_ok;

  // A completion only counts if something is actually outstanding for that register.
  assign clr_ok = clr_i && (cnt_q != '0) && busy_q[clr_addr_i];
  assign inc_ok = inc_i && (cnt_q != CNT_W'(MAX_LONG));

  // Next busy vector and count; a set beats a clear on the same register.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (clr_ok) busy_d[clr_addr_i] = 1'b0;
    if (set_i)  busy_d[set_rd_i]   = 1'b1;
    busy_d[0] = 1'b0;
    case ({inc_ok, clr_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign long_cnt_o = cnt_q;

  // A completion with nothing outstanding points at a broken long-latency pipe.
  lw_done_valid_a : assert property (@(posedge clk) disable iff (!rst_n)
    clr_i |-> ((cnt_q != '0) && busy_q[clr_addr_i]));

endmodule

// File: rtl/fw_hazard_unit.sv
// RAW forwarding and stall unit for ID; optional perf counters under HAZ_PERF_EN.
module fw_hazard_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NRP      = 2,
  parameter int unsigned NSTG     = 3,
  parameter int unsigned MAX_LONG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fw_hazard_unit_if.slave   bus
);
  import fw_pkg::*;

  localparam int unsigned CNT_W = $clog2(MAX_LONG + 1);

  logic [NREG-1:0]  busy;
  logic [CNT_W-1:0] long_cnt;
  logic [NRP-1:0]   port_stall;
  logic             issue_stall;
  logic             stall_c;
  logic             accept;
`ifdef HAZ_PERF_EN
  logic [NRP-1:0]   port_fwd;
`endif

  for (genvar p = 0; p < NRP; p++) begin : g_port
    fwd_src_e        src;
    logic            stl;
    logic [XLEN-1:0] data;

    // Source resolution: youngest matching stage, then long-latency bypass, then scoreboard.
    always_comb begin : resolve
      logic hit;
      hit = 1'b0;
      src = SRC_REG;
      stl = 1'b0;
      if (bus.rs_re_i[p] && (bus.rs_addr_i[p] != '0)) begin
        for (int s = 0; s < NSTG; s++) begin
          if (!hit && bus.stg_we_i[s] && (bus.stg_addr_i[s] == bus.rs_addr_i[p])) begin
            hit = 1'b1;
            if (bus.stg_dv_i[s]) src = SRC_STG;
            else                 stl = 1'b1;
          end
        end
        if (!hit) begin
          if (bus.lw_done_i && (bus.lw_addr_i == bus.rs_addr_i[p])) src = SRC_LW;
          else if (busy[bus.rs_addr_i[p]])                          stl = 1'b1;
        end
      end
    end

    // Data mux for the chosen source.
    always_comb begin : select
      data = bus.rs_data_reg_i[p];
      case (src)
        SRC_STG: begin
          for (int s = NSTG - 1; s >= 0; s--) begin
            if (bus.stg_we_i[s] && (bus.stg_addr_i[s] == bus.rs_addr_i[p])) data = bus.stg_data_i[s];
          end
        end
        SRC_LW:  data = bus.lw_data_i;
        default: data = bus.rs_data_reg_i[p];
      endcase
    end

    assign port_stall[p]    = stl;
    assign bus.rs_data_o[p] = rst_n ? data : '0;
`ifdef HAZ_PERF_EN
    assign port_fwd[p]      = (src != SRC_REG);
`endif
  end

  assign issue_stall = (bus.issue_long_i && (long_cnt == CNT_W'(MAX_LONG)))
                     || (bus.issue_we_i && busy[bus.issue_rd_i]);
  assign stall_c     = rst_n && !bus.flush_i && ((|port_stall) || issue_stall);
  assign accept      = bus.issue_i && !stall_c && !bus.flush_i;

  fw_scoreboard #(
    .MAX_LONG (MAX_LONG),
    .CNT_W    (CNT_W)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      (accept && bus.issue_we_i && bus.issue_long_i && (bus.issue_rd_i != '0)),
    .set_rd_i   (bus.issue_rd_i),
    .inc_i      (accept && bus.issue_long_i),
    .clr_i      (bus.lw_done_i),
    .clr_addr_i (bus.lw_addr_i),
    .busy_o     (busy),
    .long_cnt_o (long_cnt)
  );

  assign bus.stall_o    = stall_c;
  assign bus.long_cnt_o = long_cnt;

`ifdef HAZ_PERF_EN
  logic [31:0] perf_stall_q, perf_fwd_q, fwd_add;

  // Number of ports bypassed this cycle.
  always_comb begin
    fwd_add = '0;
    for (int p = 0; p < NRP; p++) fwd_add = fwd_add + 32'(port_fwd[p]);
  end

  // Free-running, wrapping event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_fwd_q   <= '0;
    end else begin
      perf_stall_q <= perf_stall_q + 32'(stall_c);
      perf_fwd_q   <= perf_fwd_q + fwd_add;
    end
  end

  assign bus.perf_stall_o = perf_stall_q;
  assign bus.perf_fwd_o   = perf_fwd_q;
`else
  assign bus.perf_stall_o = '0;
  assign bus.perf_fwd_o   = '0;
`endif

endmodule
